// File: rtl/counter_pkg.sv
// Shared counter package.
// Holds the width constant used by both the up counter and the down counter,
// so stages built from either family cascade at the same default width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

endpackage : counter_pkg

// File: rtl/down_count_cell.sv
// One-bit down-counter cell.
// Ports:
//   clk        - rising-edge clock
//   clear      - asynchronous active-high clear, forces q_bit to 0
//   toggle     - flip q_bit at the next edge (borrow chain from the parent)
//   load       - take d_bit at the next edge, overrides everything but clear
//   d_bit      - load value for this bit
//   reload_bit - stored reload value for this bit
//   reload_sel - take reload_bit at the next edge (terminal count, auto-reload)
//   q_bit      - registered count bit
module down_count_cell (
  input  logic clk,
  input  logic clear,
  input  logic toggle,
  input  logic load,
  input  logic d_bit,
  input  logic reload_bit,
  input  logic reload_sel,
  output logic q_bit
);

  // Priority is clear > load > reload > toggle > hold. The parent only raises
  // reload_sel when load is low, so the load/reload ordering is a safety net.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q_bit <= 1'b0;
    end else if (load) begin
      q_bit <= d_bit;
    end else if (reload_sel) begin
      q_bit <= reload_bit;
    end else if (toggle) begin
      q_bit <= ~q_bit;
    end
  end

endmodule : down_count_cell

// File: rtl/down_counter_with_load.sv
// Loadable, cascadable binary down counter with optional auto-reload.
// Ports:
//   clk       - rising-edge clock
//   clear     - asynchronous active-high clear of count and reload register
//   enable    - count-down enable (chain from a lower stage's borrow)
//   load      - synchronous load of d into count and reload register
//   d         - load value
//   reload_en - 1: reload at terminal count, 0: wrap to all-ones
//   q         - registered count
//   zero      - q == 0
//   borrow    - terminal count / cascade output: enable & ~load & zero
module down_counter_with_load
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             reload_en,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow
);

  logic [WIDTH-1:0] reload_val;
  logic [WIDTH-1:0] low_zero;
  logic [WIDTH-1:0] toggle;
  logic             count_en;
  logic             reload_sel;
  logic             run_zero;

  // The reload value only moves on load or clear; counting never touches it.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      reload_val <= '0;
    end else if (load) begin
      reload_val <= d;
    end
  end

  assign count_en   = enable & ~load;
  assign zero       = (q == '0);
  assign borrow     = count_en & zero;
  assign reload_sel = borrow & reload_en;

  // Bit i toggles when every lower bit is 0: subtracting 1 borrows through
  // exactly those bits. At terminal count every bit toggles, giving all-ones.
  always_comb begin
    low_zero = '0;
    run_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      low_zero[i] = run_zero;
      run_zero    = run_zero & ~q[i];
    end
  end

  assign toggle = {WIDTH{count_en}} & low_zero;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    down_count_cell u_cell (
      .clk        (clk),
      .clear      (clear),
      .toggle     (toggle[i]),
      .load       (load),
      .d_bit      (d[i]),
      .reload_bit (reload_val[i]),
      .reload_sel (reload_sel),
      .q_bit      (q[i])
    );
  end

endmodule : down_counter_with_load

// File: tb/tb_down_counter_with_load.sv
// Self-checking bench for down_counter_with_load: a single 4-bit counter
// driven against a behavioural model through a scoreboard queue, plus a
// two-stage cascade checked as an 8-bit down counter.
module tb_down_counter_with_load;

  logic       clk = 1'b0;
  logic       clear;
  logic       enable;
  logic       load;
  logic [3:0] d;
  logic       reload_en;
  logic [3:0] q;
  logic       zero;
  logic       borrow;

  logic       cas_load;
  logic       cas_en;
  logic [3:0] lo_q;
  logic [3:0] hi_q;
  logic       lo_zero;
  logic       hi_zero;
  logic       lo_borrow;
  logic       hi_borrow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] q;
    logic       zero;
    logic       borrow;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] casQ[$];

  logic [3:0] mq;
  logic [3:0] mr;
  logic [7:0] cq;
  int         pulses;

  always #5 clk = ~clk;

  down_counter_with_load #(.WIDTH(4)) dut (
    .clk(clk), .clear(clear), .enable(enable), .load(load), .d(d),
    .reload_en(reload_en), .q(q), .zero(zero), .borrow(borrow)
  );

  down_counter_with_load #(.WIDTH(4)) u_lo (
    .clk(clk), .clear(clear), .enable(cas_en), .load(cas_load), .d(4'h0),
    .reload_en(1'b0), .q(lo_q), .zero(lo_zero), .borrow(lo_borrow)
  );

  down_counter_with_load #(.WIDTH(4)) u_hi (
    .clk(clk), .clear(clear), .enable(lo_borrow), .load(cas_load), .d(4'h1),
    .reload_en(1'b0), .q(hi_q), .zero(hi_zero), .borrow(hi_borrow)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, push what the model says
  // the outputs must be this cycle, compare, then advance the model to the
  // state the next rising edge produces.
  task automatic applyStimulus(input logic ld, input logic [3:0] dv,
                               input logic en, input logic re);
    exp_t e;
    exp_t got;
    @(negedge clk);
    load = ld; d = dv; enable = en; reload_en = re;
    e.q = mq;
    e.zero = (mq == 4'h0);
    e.borrow = en & ~ld & (mq == 4'h0);
    expQ.push_back(e);
    #2;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      got = expQ.pop_front();
      checkOutput("q", {4'h0, q}, {4'h0, got.q});
      checkOutput("zero", {7'h0, zero}, {7'h0, got.zero});
      checkOutput("borrow", {7'h0, borrow}, {7'h0, got.borrow});
    end
    if (ld) begin
      mq = dv;
      mr = dv;
    end else if (en) begin
      if (mq == 4'h0) mq = re ? mr : 4'hF;
      else mq = mq - 4'h1;
    end
  endtask

  // Cascade step: both stages load together; the pair must act as one
  // 8-bit down counter with wrap.
  task automatic cascadeStep(input logic ld, input logic en);
    logic [7:0] want;
    @(negedge clk);
    cas_load = ld; cas_en = en;
    casQ.push_back(cq);
    #2;
    if (casQ.size() == 0) begin
      checkOutput("cas_scoreboard_empty", 8'd1, 8'd0);
    end else begin
      want = casQ.pop_front();
      checkOutput("cascade_q", {hi_q, lo_q}, want);
    end
    if (ld) cq = 8'h10;
    else if (en) cq = cq - 8'h1;
  endtask

  // Assert clear between edges and hold it across an edge with enable high.
  task automatic clearMidCycle();
    @(posedge clk);
    #3;
    checkOutput("pre_clear_q", {4'h0, q}, {4'h0, mq});
    clear = 1'b1;
    #1;
    checkOutput("clear_q_async", {4'h0, q}, 8'h00);
    checkOutput("clear_zero", {7'h0, zero}, 8'h01);
    enable = 1'b1; load = 1'b0;
    #1;
    checkOutput("clear_borrow", {7'h0, borrow}, 8'h01);
    @(posedge clk);
    #1;
    checkOutput("clear_hold_q", {4'h0, q}, 8'h00);
    @(negedge clk);
    enable = 1'b0;
    clear = 1'b0;
    mq = 4'h0; mr = 4'h0; cq = 8'h00;
  endtask

  initial begin
    clear = 1'b1; enable = 1'b0; load = 1'b0; d = 4'h0; reload_en = 1'b0;
    cas_load = 1'b0; cas_en = 1'b0;
    mq = 4'h0; mr = 4'h0; cq = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_q", {4'h0, q}, 8'h00);
    checkOutput("reset_zero", {7'h0, zero}, 8'h01);
    checkOutput("reset_borrow", {7'h0, borrow}, 8'h00);
    @(negedge clk);
    clear = 1'b0;

    // Async clear with q = A
    applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    clearMidCycle();

    // Free-run wrap: 2,1,0,F,E,D
    applyStimulus(1'b1, 4'h2, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);

    // Auto-reload of 3 over 12 enabled cycles
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b1, 1'b1);
      if (borrow === 1'b1) pulses++;
    end
    checkOutput("reload_pulses", pulses[7:0], 8'd3);

    // Priority: load beats enable at terminal count
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'h5, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);

    // Divide-by-1: borrow follows enable, q stays 0
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);

    // Hold: q = 7 for 5 cycles
    applyStimulus(1'b1, 4'h7, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);

    // Random mix of load/enable/reload_en
    for (int i = 0; i < 40; i++) begin
      applyStimulus(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // After clear with no load, auto-reload behaves as N = 0
    clearMidCycle();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);

    // Cascade: 10, 0F, ..., 00, FF
    cascadeStep(1'b1, 1'b0);
    for (int i = 0; i < 19; i++) cascadeStep(1'b0, 1'b1);
    cascadeStep(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_down_counter_with_load

// File: doc/down_counter_with_load.md
# down_counter_with_load

Synchronous, loadable, cascadable binary down counter with enable, an asynchronous clear, and an optional auto-reload mode. It is the count-down counterpart of the team's up counter with enable input. It serves as a programmable period generator and timeout timer: `borrow` marks the terminal count. `borrow` chains into the `enable` of the next, more-significant stage, the same way enables ripple between up-counter stages.

## Interface
Parameters:
- `WIDTH`, 4, counter width in bits (≥ 2).

Ports:
- `clk` in 1: rising-edge clock; the only clock.
- `clear` in 1: reset; asynchronous, active-high. Forces `q` and the reload register to 0.
- `enable` in 1: count-down enable, sampled at the rising edge of `clk`.
- `load` in 1: synchronous load of `d` into `q` and the reload register.
- `d` in WIDTH: load value.
- `reload_en` in 1: 1 selects auto-reload at terminal count; 0 selects wrap to all-ones.
- `q` out WIDTH: current count, registered.
- `zero` out 1: `q == 0`, combinational from `q`.
- `borrow` out 1: `enable & ~load & (q == 0)`, combinational. It is the cascade and terminal-count output.

## Operation
- Priority, highest first: `clear` > `load` > `enable` > hold.
- `clear` high: `q` = 0 and reload register = 0 immediately, independent of `clk`. Outputs then read `zero` = 1 and `borrow` = `enable & ~load`.
- `load` high at an edge:
  - `q` ← `d` and reload register ← `d`.
  - `enable` is ignored that cycle.
  - `borrow` is suppressed that cycle.
- `enable` high, `load` low, `q` ≠ 0: `q` ← `q` − 1.
- `enable` high, `load` low, `q` = 0 (terminal count, `borrow` = 1):
  - `reload_en` = 1: `q` ← reload register.
  - `reload_en` = 0: `q` ← 2^WIDTH − 1 (modular wrap).
- Otherwise `q` holds.
- Period: with `reload_en` = 1 and reload value N, `borrow` asserts once every N+1 enabled cycles.
  - N = 0 gives `borrow` on every enabled cycle, with `q` stuck at 0 (divide-by-1).
- The reload register changes only on `load` or `clear`; `reload_en` may change on any cycle.
- All arithmetic is unsigned, modulo 2^WIDTH. There are no other internal states.

## Timing
- `q` updates only on the rising edge of `clk`, except for the asynchronous `clear`.
- Load-to-output latency is 1 cycle: `d` is visible on `q` after the loading edge.
- `zero` and `borrow` have 0-cycle latency from `q`, `enable` and `load`.
- `borrow` is combinational, so a cascade of k stages adds k AND delays to the top stage's enable path. Stages are not pipelined.
- `clear` deassertion must meet recovery/removal timing relative to `clk`. On the first edge after deassertion, normal priority applies.
- `clear` mid-count discards the count and the reload value. After `clear`, with no `load`, auto-reload behaves as N = 0.

## Structure
- Shared package `counter_pkg`: `DEFAULT_WIDTH` = 4, shared with the up counter.
- Sub-module `down_count_cell`: a one-bit cell with the following ports:
  - `clk`, `clear` (async, active-high).
  - `toggle`, `load`, `d_bit`, `reload_bit`, `reload_sel`.
  - Output `q_bit`.
- Toggle chain inside the parent: bit 0 toggles on the count enable. Bit i toggles when the enable is high and all lower bits are 0. This is the borrow analogue of the AND-chained toggle enables of the up counter.
- Terminal-count reload uses the per-cell `reload_sel` path:
  - `reload_en` = 1: cells load `reload_bit`.
  - `reload_en` = 0: every bit toggles from 0 to 1.

## Test plan
- Async clear: assert `clear` between edges with `q` = 4'hA → `q` = 0 immediately, `zero` = 1; no change at the next edge while `clear` is held.
- Free-run wrap: `reload_en` = 0, load 4'h2, `enable` = 1 → `q` = 2,1,0,F,E; `borrow` = 1 only in the cycle where `q` = 0.
- Auto-reload: `reload_en` = 1, load 4'h3, `enable` = 1 for 12 cycles → `q` = 3,2,1,0,3,2,1,0,…; `borrow` asserts every 4th cycle (3 pulses).
- Priority: `load` = 1 with `d` = 4'h5, `enable` = 1, `q` = 0 → `borrow` = 0 that cycle; next `q` = 5, not F and not a reload value.
- Cascade: two 4-bit instances, low `borrow` → high `enable`; load 8'h10 (high = 1, low = 0) and enable → 8-bit sequence 10, 0F, 0E, …, 00, FF.
- Divide-by-1 and hold: `reload_en` = 1, load 0, toggle `enable` 1,0,1 → `borrow` follows `enable` and `q` stays 0; with `enable` = 0, `q` = 7 holds for 5 cycles.
